// File: rtl/switch_nport_if.sv
// switch_nport_if: bus between the packet source/consumers and the switch.
// Source side: vld/rdy/addr/data. Per-port consumer side: out_vld/out_rdy/
// out_addr/out_data (port p at slice p). drop_cnt: blocked-broadcast count.
interface switch_nport_if #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int NUM_PORTS = 4
);
    logic                          vld;
    logic                          rdy;
    logic [ADDR_W-1:0]             addr;
    logic [DATA_W-1:0]             data;
    logic [NUM_PORTS-1:0]          out_vld;
    logic [NUM_PORTS-1:0]          out_rdy;
    logic [NUM_PORTS*ADDR_W-1:0]   out_addr;
    logic [NUM_PORTS*DATA_W-1:0]   out_data;
    logic [15:0]                   drop_cnt;

    modport master (
        output vld, addr, data, out_rdy,
        input  rdy, out_vld, out_addr, out_data, drop_cnt
    );

    modport slave (
        input  vld, addr, data, out_rdy,
        output rdy, out_vld, out_addr, out_data, drop_cnt
    );
endinterface

// File: rtl/switch_nport.sv
// switch_nport: routes {addr,data} by the top address bits to one of
// NUM_PORTS output FIFOs, or to all of them for the all-ones address.
// Ports: clk, rstn (async active-low), bus (switch_nport_if.slave).
module switch_nport #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    switch_nport_if.slave   bus
);
    localparam int PSEL_W = $clog2(NUM_PORTS);
    localparam int IDX_W  = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int ENT_W  = ADDR_W + DATA_W;

    logic                         bcast;
    logic [PSEL_W-1:0]            dest;
    logic                         accept;
    logic [NUM_PORTS-1:0]         full;
    logic [NUM_PORTS-1:0]         empty;
    logic [NUM_PORTS-1:0]         push;
    logic [NUM_PORTS-1:0]         pop;
    logic [NUM_PORTS*ADDR_W-1:0]  head_addr;
    logic [NUM_PORTS*DATA_W-1:0]  head_data;
    logic [15:0]                  drop_cnt;

    assign bcast = &bus.addr;
    assign dest  = bus.addr[ADDR_W-1 -: PSEL_W];

    // Full is taken from pointers before any pop this cycle: no pass-through.
    assign bus.rdy = rstn && (bcast ? ~|full : ~full[dest]);
    assign accept  = bus.vld && bus.rdy;

    always_comb begin
        push = '0;
        if (accept) begin
            push = bcast ? '1 : (NUM_PORTS'(1) << dest);
        end
    end

    assign pop = ~empty & bus.out_rdy;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [ENT_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [ENT_W-1:0] head;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[p]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[p])  rd_ptr <= rd_ptr + 1'b1;
            end
        end

        // Storage needs no reset: outputs are forced to zero while empty.
        always_ff @(posedge clk) begin
            if (push[p]) mem[wr_ptr[IDX_W-1:0]] <= {bus.addr, bus.data};
        end

        assign full[p]  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                          (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
        assign empty[p] = (wr_ptr == rd_ptr);
        assign head     = empty[p] ? '0 : mem[rd_ptr[IDX_W-1:0]];

        assign head_addr[p*ADDR_W +: ADDR_W] = head[ENT_W-1 -: ADDR_W];
        assign head_data[p*DATA_W +: DATA_W] = head[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (bus.vld && bcast && !bus.rdy && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign bus.out_vld  = ~empty;
    assign bus.out_addr = head_addr;
    assign bus.out_data = head_data;
    assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_switch_nport.sv
// tb_switch_nport: random and directed traffic against a queue-based model
// of the switch; outputs checked every cycle on the falling clock edge.
module tb_switch_nport;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int NP    = 4;
    localparam int DEPTH = 4;
    localparam int PW    = $clog2(NP);

    typedef logic [AW+DW-1:0] ent_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    ent_t        q[NP][$];
    logic [15:0] m_drop = '0;

    always #5 clk = ~clk;

    switch_nport_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_PORTS(NP)) bus ();

    switch_nport #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_rdy(input logic [AW-1:0] a);
        int d;
        if (!rstn) return 1'b0;
        if (a == '1) begin
            for (int p = 0; p < NP; p++)
                if (q[p].size() >= DEPTH) return 1'b0;
            return 1'b1;
        end
        d = int'(a[AW-1 -: PW]);
        return q[d].size() < DEPTH;
    endfunction

    task automatic check_outs();
        ent_t h;
        for (int p = 0; p < NP; p++) begin
            h = (q[p].size() != 0) ? q[p][0] : '0;
            chk($sformatf("out_vld[%0d]", p), 32'(bus.out_vld[p]),
                32'(q[p].size() != 0));
            chk($sformatf("out_addr[%0d]", p), 32'(bus.out_addr[p*AW +: AW]),
                32'(h[AW+DW-1 -: AW]));
            chk($sformatf("out_data[%0d]", p), 32'(bus.out_data[p*DW +: DW]),
                32'(h[DW-1:0]));
        end
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    endtask

    // One clock: apply inputs, check rdy, step model at the edge, check outputs.
    task automatic tick(input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NP-1:0] ordy,
                        output logic acc);
        logic          er;
        logic [NP-1:0] popm;
        int            dst;
        bus.vld     = v;
        bus.addr    = a;
        bus.data    = d;
        bus.out_rdy = ordy;
        #1;
        er = m_rdy(a);
        chk("rdy", 32'(bus.rdy), 32'(er));
        acc = v && er;
        dst = int'(a[AW-1 -: PW]);
        for (int p = 0; p < NP; p++)
            popm[p] = (q[p].size() != 0) && ordy[p];
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            if (popm[p]) void'(q[p].pop_front());
            if (acc && (a == '1 || dst == p)) q[p].push_back({a, d});
        end
        if (v && a == '1 && !er && m_drop != 16'hFFFF) m_drop++;
        @(negedge clk);
        check_outs();
    endtask

    // Hold one transfer until accepted; ready bits in rmask re-randomised.
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NP-1:0] base, input logic [NP-1:0] rmask);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++)
            tick(1'b1, a, d, base | (rmask & NP'($urandom)), acc);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        logic acc;
        repeat (DEPTH + 2) tick(1'b0, '0, '0, '1, acc);
    endtask

    initial begin
        logic          acc;
        logic          pv;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;

        bus.vld = 1'b0; bus.addr = '0; bus.data = '0; bus.out_rdy = '0;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdy", 32'(bus.rdy), 32'd0);
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_out_data", 32'(bus.out_data[31:0]), 32'd0);
        chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel_rdy", 32'(bus.rdy), 32'd1);

        // Routing to every port
        send(8'h05, 16'h1111, '1, '0);
        send(8'h45, 16'h2222, '1, '0);
        send(8'h85, 16'h3333, '1, '0);
        send(8'hC5, 16'h4444, '1, '0);
        drain();

        // Port 2 stalled: fills, others unaffected, then drains in order
        for (int i = 0; i < DEPTH; i++)
            send(8'h80, 16'hA000 + 16'(i), 4'b1011, '0);
        tick(1'b1, 8'h80, 16'hA004, 4'b1011, acc);
        chk("bp_5th_acc", 32'(acc), 32'd0);
        send(8'h10, 16'h5555, 4'b1011, '0);
        send(8'h80, 16'hA004, 4'b1111, '0);
        drain();

        // Broadcast to empty ports, then blocked by full port 3
        send(8'hFF, 16'hABCD, '1, '0);
        drain();
        for (int i = 0; i < DEPTH; i++)
            send(8'hC0 + 8'(i), 16'hC000 + 16'(i), 4'b0111, '0);
        repeat (3) tick(1'b1, 8'hFF, 16'hBEEF, 4'b0111, acc);
        chk("bc_drop3", 32'(bus.drop_cnt), 32'd3);
        send(8'hFF, 16'hBEEF, '1, '0);
        drain();

        // Asynchronous reset with 3 entries pending in port 1
        for (int i = 0; i < 3; i++)
            send(8'h40 + 8'(i), 16'hD000 + 16'(i), 4'b1101, '0);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(bus.rdy), 32'd0);
        chk("mid_rst_vld", 32'(bus.out_vld), 32'd0);
        chk("mid_rst_addr", 32'(bus.out_addr), 32'd0);
        chk("mid_rst_data", 32'(bus.out_data[31:0]), 32'd0);
        chk("mid_rst_drop", 32'(bus.drop_cnt), 32'd0);
        for (int p = 0; p < NP; p++) q[p].delete();
        m_drop = '0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        bus.addr = 8'h40;
        #1;
        chk("mid_rel_rdy40", 32'(bus.rdy), 32'd1);
        bus.addr = 8'hFF;
        #1;
        chk("mid_rel_rdyFF", 32'(bus.rdy), 32'd1);
        check_outs();

        // Push and pop port 0 together for 10 cycles
        send(8'h00, 16'h7000, '1, '0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 8'h00 + 8'(i), 16'h7001 + 16'(i), '1, acc);
            chk("simul_acc", 32'(acc), 32'd1);
        end
        drain();

        // Wrap-around on port 1 with random consumer readiness
        for (int i = 0; i < 3 * DEPTH; i++)
            send(8'h40 | 8'($urandom_range(0, 63)), 16'($urandom), 4'b1101, 4'b0010);
        drain();

        // Random traffic, source holds until accepted
        pv = 1'b0; pa = '0; pd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                pa = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                pd = 16'($urandom);
            end
            tick(pv, pa, pd, NP'($urandom), acc);
            if (acc) pv = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
